hdd_xfer_ctrl: RTL and testbench



---
 rtl/hdd_pkg.sv | 29 ++
 rtl/hdd_rr_arb.sv | 20 ++
 rtl/hdd_xfer_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_hdd_xfer_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hdd_pkg                                                          |
// | Shared types and constants for the HDD sector-transfer sequencer |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package hdd_pkg;

    localparam int SEC_AW = 9;
    localparam int BLK_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } xfer_state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } xfer_op_t;

    function automatic logic [31:0] make_lba(input logic unit, input logic [BLK_W-1:0] sector);
        return {15'b0, unit, sector};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hdd_rr_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hdd_rr_arb                                                       |
// | Two-requester round-robin arbiter; the unit not served last wins |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module hdd_rr_arb (
    input  logic [1:0] pend,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |pend;
        grant = pend[~last] ? ~last : last;
    end

endmodule
`default_nettype wire

// File: rtl/hdd_xfer_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hdd_xfer_ctrl                                                    |
// | Serialises two HDD units' sector requests onto one host block    |
// | channel. Define HDD_XFER_WRITE_EN to serve write requests.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module hdd_xfer_ctrl
    import hdd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int TO_W           = 20
) (
    input  logic                 CLK_14M,
    input  logic                 RESET,
    input  logic [1:0]           u_read,
    input  logic [1:0]           u_write,
    input  logic [2*BLK_W-1:0]   u_sector,
    output logic [2*SEC_AW-1:0]  u_ram_addr,
    output logic [15:0]          u_ram_di,
    output logic [1:0]           u_ram_we,
    input  logic [15:0]          u_ram_do,
    output logic [1:0]           u_busy,
    output logic [1:0]           u_err,
    output logic [31:0]          blk_lba,
    output logic                 blk_rd,
    output logic                 blk_wr,
    input  logic                 blk_ack,
    input  logic [SEC_AW-1:0]    blk_addr,
    input  logic [7:0]           blk_dout,
    input  logic                 blk_we,
    output logic [7:0]           blk_din,
    output logic                 done
);

`ifdef HDD_XFER_WRITE_EN
    localparam logic c_WR_EN = 1'b1;
`else
    localparam logic c_WR_EN = 1'b0;
`endif
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    xfer_state_t      r_state, w_state_nxt;
    xfer_op_t         r_op, w_op_nxt;
    logic             r_g, w_g_nxt;
    logic             r_last, w_last_nxt;
    logic [TO_W-1:0]  r_cnt, w_cnt_nxt;
    logic [31:0]      r_lba, w_lba_nxt;
    logic [1:0]       r_pend_rd, w_pend_rd_nxt;
    logic [1:0]       r_pend_wr, w_pend_wr_nxt;
    logic [1:0]       r_err, w_err_nxt;
    logic [1:0]       r_busy, w_busy_nxt;
    logic             r_blk_rd, w_rd_nxt;
    logic             r_blk_wr, w_wr_nxt;
    logic             r_done, w_done_nxt;
    logic [1:0]       w_wr_req;
    logic             w_arb_grant, w_arb_valid;
    logic [BLK_W-1:0] w_sec_sel;
    logic [7:0]       w_din_sel;

    // Write pulses vanish here when writes are disabled; pend_wr then never sets
    assign w_wr_req  = u_write & {2{c_WR_EN}};
    assign w_sec_sel = w_arb_grant ? u_sector[2*BLK_W-1:BLK_W] : u_sector[BLK_W-1:0];

    hdd_rr_arb u_arb (
        .pend  (r_pend_rd | r_pend_wr),
        .last  (r_last),
        .grant (w_arb_grant),
        .valid (w_arb_valid)
    );

    always_ff @(posedge CLK_14M) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_RD;
            r_g       <= 1'b0;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_lba     <= '0;
            r_pend_rd <= '0;
            r_pend_wr <= '0;
            r_err     <= '0;
            r_busy    <= '0;
            r_blk_rd  <= 1'b0;
            r_blk_wr  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_op      <= w_op_nxt;
            r_g       <= w_g_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_lba     <= w_lba_nxt;
            r_pend_rd <= w_pend_rd_nxt;
            r_pend_wr <= w_pend_wr_nxt;
            r_err     <= w_err_nxt;
            r_busy    <= w_busy_nxt;
            r_blk_rd  <= w_rd_nxt;
            r_blk_wr  <= w_wr_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_op_nxt      = r_op;
        w_g_nxt       = r_g;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_cnt;
        w_lba_nxt     = r_lba;
        w_rd_nxt      = r_blk_rd;
        w_wr_nxt      = r_blk_wr;
        w_done_nxt    = 1'b0;
        // Pending bits stay set through the transaction, so repeat pulses are absorbed
        w_pend_rd_nxt = r_pend_rd | u_read;
        w_pend_wr_nxt = r_pend_wr | w_wr_req;
        w_err_nxt     = r_err & ~(u_read | w_wr_req);

        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = ST_REQ;
                    w_g_nxt     = w_arb_grant;
                    w_last_nxt  = w_arb_grant;
                    w_op_nxt    = r_pend_rd[w_arb_grant] ? OP_RD : OP_WR;
                    w_lba_nxt   = make_lba(w_arb_grant, w_sec_sel);
                    w_cnt_nxt   = '0;
                    w_rd_nxt    = r_pend_rd[w_arb_grant];
                    w_wr_nxt    = ~r_pend_rd[w_arb_grant] & c_WR_EN;
                end
            end
            ST_REQ: begin
                if (blk_ack) begin
                    w_state_nxt = ST_XFER;
                    w_rd_nxt    = 1'b0;
                    w_wr_nxt    = 1'b0;
                end else if (r_cnt == c_TO_LAST) begin
                    w_state_nxt     = ST_DONE;
                    w_rd_nxt        = 1'b0;
                    w_wr_nxt        = 1'b0;
                    w_done_nxt      = 1'b1;
                    w_err_nxt[r_g]  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + TO_W'(1);
                end
            end
            ST_XFER: begin
                if (!blk_ack) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                if (r_op == OP_RD) w_pend_rd_nxt[r_g] = 1'b0;
                else               w_pend_wr_nxt[r_g] = 1'b0;
            end
        endcase

        w_busy_nxt = w_pend_rd_nxt | w_pend_wr_nxt;
        if (w_state_nxt != ST_IDLE) w_busy_nxt[w_g_nxt] = 1'b1;
    end

    // Buffer routing is combinational so the host sees the unit RAM's native latency
    always_comb begin
        u_ram_addr = '0;
        u_ram_di   = '0;
        u_ram_we   = '0;
        w_din_sel  = r_g ? u_ram_do[15:8] : u_ram_do[7:0];
        blk_din    = '0;
        if (r_state == ST_XFER) begin
            if (r_g) begin
                u_ram_addr[2*SEC_AW-1:SEC_AW] = blk_addr;
                u_ram_di[15:8]                = blk_dout;
                u_ram_we[1]                   = blk_we & (r_op == OP_RD);
            end else begin
                u_ram_addr[SEC_AW-1:0] = blk_addr;
                u_ram_di[7:0]          = blk_dout;
                u_ram_we[0]            = blk_we & (r_op == OP_RD);
            end
            blk_din = w_din_sel & {8{c_WR_EN}};
        end
    end

    assign blk_lba = r_lba;
    assign blk_rd  = r_blk_rd;
    assign blk_wr  = r_blk_wr & c_WR_EN;
    assign done    = r_done;
    assign u_busy  = r_busy;
    assign u_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hdd_xfer_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_hdd_xfer_ctrl                                                 |
// | Scoreboard bench: host model, unit buffer RAMs, request queue    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_hdd_xfer_ctrl;

    logic        CLK_14M = 1'b0;
    logic        RESET   = 1'b1;
    logic [1:0]  u_read  = '0;
    logic [1:0]  u_write = '0;
    logic [31:0] u_sector = '0;
    logic [17:0] u_ram_addr;
    logic [15:0] u_ram_di;
    logic [1:0]  u_ram_we;
    logic [15:0] u_ram_do;
    logic [1:0]  u_busy, u_err;
    logic [31:0] blk_lba;
    logic        blk_rd, blk_wr;
    logic        blk_ack  = 1'b0;
    logic [8:0]  blk_addr = '0;
    logic [7:0]  blk_dout = '0;
    logic        blk_we   = 1'b0;
    logic [7:0]  blk_din;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] lba;
        logic        rd;
        logic        wr;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] din_q[$];
    logic [7:0] mem0 [0:511];
    logic [7:0] mem1 [0:511];
    logic [7:0] sh0  [0:511];
    logic [7:0] sh1  [0:511];
    logic [7:0] q0 = '0, q1 = '0;

    always #5 CLK_14M = ~CLK_14M;

    // Unit sector buffers with one cycle of registered read latency
    always @(posedge CLK_14M) begin
        if (u_ram_we[0]) mem0[u_ram_addr[8:0]] <= u_ram_di[7:0];
        if (u_ram_we[1]) mem1[u_ram_addr[17:9]] <= u_ram_di[15:8];
        q0 <= mem0[u_ram_addr[8:0]];
        q1 <= mem1[u_ram_addr[17:9]];
    end
    assign u_ram_do = {q1, q0};

    hdd_xfer_ctrl #(.TIMEOUT_CYCLES(16), .TO_W(20)) dut (
        .CLK_14M    (CLK_14M),
        .RESET      (RESET),
        .u_read     (u_read),
        .u_write    (u_write),
        .u_sector   (u_sector),
        .u_ram_addr (u_ram_addr),
        .u_ram_di   (u_ram_di),
        .u_ram_we   (u_ram_we),
        .u_ram_do   (u_ram_do),
        .u_busy     (u_busy),
        .u_err      (u_err),
        .blk_lba    (blk_lba),
        .blk_rd     (blk_rd),
        .blk_wr     (blk_wr),
        .blk_ack    (blk_ack),
        .blk_addr   (blk_addr),
        .blk_dout   (blk_dout),
        .blk_we     (blk_we),
        .blk_din    (blk_din),
        .done       (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic push_exp(input logic unit, input logic [15:0] sec, input logic is_wr);
        exp_t e;
        e.lba = {15'b0, unit, sec};
        e.rd  = ~is_wr;
        e.wr  = is_wr;
        exp_q.push_back(e);
    endtask

    task automatic pulse(input logic [1:0] rd, input logic [1:0] wr);
        @(negedge CLK_14M);
        u_read  = rd;
        u_write = wr;
        @(negedge CLK_14M);
        u_read  = '0;
        u_write = '0;
    endtask

    task automatic wait_req(output logic unit, output logic ok);
        exp_t e;
        int   n = 0;
        ok   = 1'b0;
        unit = 1'b0;
        while (!(blk_rd || blk_wr) && n < 200) begin
            @(negedge CLK_14M);
            n++;
        end
        if (!(blk_rd || blk_wr)) begin
            check_eq("req_seen", 32'd0, 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            check_eq("sb_unexpected_req", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check_eq("blk_lba", blk_lba, e.lba);
        check_eq("blk_rd", {31'b0, blk_rd}, {31'b0, e.rd});
        check_eq("blk_wr", {31'b0, blk_wr}, {31'b0, e.wr});
        unit = blk_lba[16];
        check_eq("busy_active", {31'b0, u_busy[unit]}, 32'd1);
        ok = 1'b1;
    endtask

    task automatic host_txn(input logic [7:0] key);
        logic       unit, ok, is_wr;
        logic [7:0] v;
        wait_req(unit, ok);
        if (!ok) return;
        is_wr   = blk_wr;
        blk_ack = 1'b1;
        @(negedge CLK_14M);
        check_eq("req_drop", {30'b0, blk_rd, blk_wr}, 32'd0);
        if (!is_wr) begin
            for (int i = 0; i < 512; i++) begin
                v        = 8'(i) ^ key;
                blk_addr = 9'(i);
                blk_dout = v;
                blk_we   = 1'b1;
                if (unit) sh1[i] = v;
                else      sh0[i] = v;
                @(negedge CLK_14M);
            end
        end else begin
            // Strobe asserted with junk data: a write op must leave the buffer untouched
            blk_we   = 1'b1;
            blk_dout = 8'hFF;
            for (int i = 0; i <= 64; i++) begin
                if (i > 0) check_eq("blk_din", blk_din, din_q.pop_front());
                if (i < 64) begin
                    blk_addr = 9'(i);
                    din_q.push_back(unit ? sh1[i] : sh0[i]);
                end
                @(negedge CLK_14M);
            end
        end
        blk_ack  = 1'b0;
        blk_we   = 1'b0;
        blk_addr = '0;
        blk_dout = '0;
        @(negedge CLK_14M);
        check_eq("done_pulse", {31'b0, done}, 32'd1);
        @(negedge CLK_14M);
        check_eq("done_single", {31'b0, done}, 32'd0);
        for (int i = 0; i < (is_wr ? 64 : 512); i++)
            check_eq("buffer", unit ? mem1[i] : mem0[i], unit ? sh1[i] : sh0[i]);
    endtask

    initial begin
        logic       unit, ok, seen;
        int         cnt;

        repeat (3) @(negedge CLK_14M);
        check_eq("rst_outs", {blk_rd, blk_wr, done, u_busy, u_err, u_ram_we}, 32'd0);
        check_eq("rst_lba", blk_lba, 32'd0);
        check_eq("rst_route", {u_ram_addr, blk_din}, 32'd0);
        RESET = 1'b0;

        // Simultaneous reads straight after reset: unit0 first
        u_sector = {16'h0B0B, 16'h0A0A};
        push_exp(1'b0, 16'h0A0A, 1'b0);
        push_exp(1'b1, 16'h0B0B, 1'b0);
        pulse(2'b11, 2'b00);
        check_eq("busy_both", u_busy, 32'd3);
        host_txn(8'h11);
        host_txn(8'h22);
        check_eq("busy_idle_rr1", u_busy, 32'd0);

        // Single unit0 read of sector 0x0123
        u_sector = {16'h0B0B, 16'h0123};
        push_exp(1'b0, 16'h0123, 1'b0);
        pulse(2'b01, 2'b00);
        check_eq("busy_after_pulse", u_busy, 32'd1);
        host_txn(8'h5A);
        check_eq("busy_fall", u_busy, 32'd0);

        // Unit0 served last, so unit1 wins this conflict
        u_sector = {16'h0C0C, 16'h0D0D};
        push_exp(1'b1, 16'h0C0C, 1'b0);
        push_exp(1'b0, 16'h0D0D, 1'b0);
        pulse(2'b11, 2'b00);
        host_txn(8'h33);
        host_txn(8'h44);
        check_eq("busy_idle_rr2", u_busy, 32'd0);

        // Unit1 write of sector 0x0040
        u_sector = {16'h0040, 16'h0D0D};
`ifdef HDD_XFER_WRITE_EN
        push_exp(1'b1, 16'h0040, 1'b1);
        pulse(2'b00, 2'b10);
        check_eq("busy_wr", u_busy, 32'd2);
        host_txn(8'h00);
`else
        pulse(2'b00, 2'b10);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | blk_wr | (|u_busy);
            @(negedge CLK_14M);
        end
        check_eq("wr_ignored", {31'b0, seen}, 32'd0);
`endif
        check_eq("busy_idle_wr", u_busy, 32'd0);

        // Unit0 read and write together: read completes first
        u_sector = {16'h0040, 16'h0200};
        push_exp(1'b0, 16'h0200, 1'b0);
`ifdef HDD_XFER_WRITE_EN
        push_exp(1'b0, 16'h0200, 1'b1);
        pulse(2'b01, 2'b01);
        host_txn(8'h66);
        host_txn(8'h00);
`else
        pulse(2'b01, 2'b01);
        host_txn(8'h66);
`endif
        check_eq("busy_idle_rw", u_busy, 32'd0);

        // Timeout: no ack ever arrives
        u_sector = {16'h0040, 16'h0777};
        push_exp(1'b0, 16'h0777, 1'b0);
        pulse(2'b01, 2'b00);
        wait_req(unit, ok);
        cnt = 0;
        while (blk_rd && cnt < 100) begin
            cnt++;
            @(negedge CLK_14M);
        end
        check_eq("to_cycles", cnt, 32'd16);
        check_eq("to_done", {31'b0, done}, 32'd1);
        check_eq("to_err", u_err, 32'd1);
        @(negedge CLK_14M);
        check_eq("to_done_single", {31'b0, done}, 32'd0);
        check_eq("to_err_sticky", u_err, 32'd1);
        push_exp(1'b0, 16'h0777, 1'b0);
        pulse(2'b01, 2'b00);
        check_eq("err_cleared", u_err, 32'd0);
        host_txn(8'h77);

        // Reset in the middle of a transfer
        u_sector = {16'h0999, 16'h0777};
        push_exp(1'b1, 16'h0999, 1'b0);
        pulse(2'b10, 2'b00);
        wait_req(unit, ok);
        blk_ack = 1'b1;
        @(negedge CLK_14M);
        blk_addr = 9'd5;
        blk_dout = 8'hA5;
        blk_we   = 1'b1;
        @(negedge CLK_14M);
        RESET = 1'b1;
        @(negedge CLK_14M);
        check_eq("mid_rst_outs", {blk_rd, blk_wr, done, u_busy, u_err, u_ram_we}, 32'd0);
        check_eq("mid_rst_lba", blk_lba, 32'd0);
        check_eq("mid_rst_route", {u_ram_addr, blk_din}, 32'd0);
        RESET = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK_14M);
            seen = seen | blk_rd | done | (|u_busy) | (|u_ram_we);
        end
        check_eq("late_ack_ignored", {31'b0, seen}, 32'd0);
        blk_ack = 1'b0;
        blk_we  = 1'b0;

        check_eq("sb_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
